// File: rtl/countdown_timer_chain.sv
// Multi-digit BCD countdown timer with per-digit radix (mm:ss capable),
// load clamping, start/pause toggle, penalty subtraction and expiry.
//
// state      | meaning
// ST_IDLE    | no valid preset, count is zero
// ST_ARMED   | nonzero preset loaded, or paused; count held
// ST_RUN     | counting down on tick, penalty applies
// ST_EXPIRED | count reached zero; held until clear or reset
module countdown_timer_chain #(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] RADIX_MASK = 4'b0010,
  parameter int                    PEN_IDX    = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tick,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_user_digits,
  input  logic                    i_start,
  input  logic                    i_penalty,
  input  logic                    i_clear,
  output logic [4*NUM_DIGITS-1:0] o_timer_count,
  output logic                    o_expired,
  output logic                    o_load_err,
  output logic [1:0]              o_config_flag
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RUN     = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_count;
  logic           r_load_err;

  logic [W-1:0]   w_dec;
  logic           w_underflow;
  logic [W-1:0]   w_next;
  logic [W-1:0]   w_clamped;
  logic           w_clamp_any;
  logic           w_load_ok;

  // Ripple-borrow subtraction of the combined tick and penalty weights.
  always_comb begin
    logic       v_borrow;
    logic [3:0] v_need;
    logic [3:0] v_radix;
    logic [3:0] v_digit;
    v_borrow = 1'b0;
    v_need   = 4'd0;
    v_radix  = 4'd10;
    v_digit  = 4'd0;
    w_dec    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v_radix = RADIX_MASK[i] ? 4'd6 : 4'd10;
      v_digit = r_count[4*i +: 4];
      v_need  = 4'(v_borrow) + 4'((i == 0) && i_tick) + 4'((i == PEN_IDX) && i_penalty);
      if (v_digit >= v_need) begin
        w_dec[4*i +: 4] = v_digit - v_need;
        v_borrow        = 1'b0;
      end else begin
        w_dec[4*i +: 4] = v_digit + v_radix - v_need;
        v_borrow        = 1'b1;
      end
    end
    w_underflow = v_borrow;
  end

  // A borrow out of the top digit means the penalty exceeded the remaining time.
  assign w_next = w_underflow ? '0 : w_dec;

  // Clamp each preset digit to its radix and flag any clamping.
  always_comb begin
    logic [3:0] v_max;
    v_max       = 4'd9;
    w_clamped   = '0;
    w_clamp_any = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v_max = RADIX_MASK[i] ? 4'd5 : 4'd9;
      if (i_user_digits[4*i +: 4] > v_max) begin
        w_clamped[4*i +: 4] = v_max;
        w_clamp_any         = 1'b1;
      end else begin
        w_clamped[4*i +: 4] = i_user_digits[4*i +: 4];
      end
    end
  end

  assign w_load_ok = (r_state == ST_IDLE) || (r_state == ST_ARMED);

  // Control FSM: clear > load > start > tick/penalty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (i_clear) begin
        r_state <= ST_IDLE;
        r_count <= '0;
      end else if (i_load) begin
        // A start arriving with load is swallowed, even when the load itself is ignored.
        if (w_load_ok) begin
          r_count    <= w_clamped;
          r_load_err <= w_clamp_any;
          r_state    <= (w_clamped == '0) ? ST_IDLE : ST_ARMED;
        end
      end else if (i_start) begin
        if (r_state == ST_ARMED)
          r_state <= ST_RUN;
        else if (r_state == ST_RUN)
          r_state <= ST_ARMED;
      end else if ((r_state == ST_RUN) && (i_tick || i_penalty)) begin
        if (w_next == '0) begin
          r_count <= '0;
          r_state <= ST_EXPIRED;
        end else begin
          r_count <= w_next;
        end
      end
    end
  end

  assign o_timer_count = r_count;
  assign o_expired     = (r_state == ST_EXPIRED);
  assign o_load_err    = r_load_err;
  assign o_config_flag = r_state;

endmodule
